decode_core: RTL and testbench

DECODE_CORE -- requirements
Module: decode_core

---
 rtl/decode_core.sv | 204 ++++++++++++++++++++
 tb/tb_decode_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_core.sv
// MIPS-I instruction decode stage: control decoding, branch/jump target generation
// and a 32x32 register file with three read ports, one write port and write-through.
module decode_core (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr,
   input  logic [31:0] PC_Plus4,
   input  logic [31:0] JrValue,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   input  logic        Write,
   output logic [31:0] DataA,
   output logic [31:0] DataB,
   output logic [31:0] DataC,
   output logic [4:0]  WriteRegister,
   output logic [31:0] AltPC,
   output logic        Link,
   output logic        RegDest,
   output logic        Jump,
   output logic        Branch,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        JumpRegister,
   output logic        SignOrZero,
   output logic        Syscall,
   output logic [5:0]  ALUControl
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LL    = 6'b110000;
   localparam logic [5:0] OP_SC    = 6'b111000;

   localparam logic [5:0] FN_SLL     = 6'b000000;
   localparam logic [5:0] FN_SRL     = 6'b000010;
   localparam logic [5:0] FN_SRA     = 6'b000011;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [5:0] FN_SYSCALL = 6'b001100;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUBU    = 6'b100011;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_XOR     = 6'b100110;
   localparam logic [5:0] FN_NOR     = 6'b100111;
   localparam logic [5:0] FN_SLT     = 6'b101010;
   localparam logic [5:0] FN_SLTU    = 6'b101011;

   localparam logic [5:0] ALU_LL = 6'b101000;
   localparam logic [5:0] ALU_SC = 6'b110110;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] regFile_q [32];
   logic        writeActive;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;

   assign opcode = Instr[31:26];
   assign rs     = Instr[25:21];
   assign rt     = Instr[20:16];
   assign rd     = Instr[15:11];
   assign imm    = Instr[15:0];
   assign funct  = Instr[5:0];

   // Writes are suppressed while reset is held so the read bypass also sees a cleared file.
   assign writeActive = RESET && Write && (WriteReg != 5'd0);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 32; i++) begin
            regFile_q[i] <= '0;
         end
      end else if (writeActive) begin
         regFile_q[WriteReg] <= WriteData;
      end
   end

   assign DataA = (rs == 5'd0) ? 32'd0 :
                  (writeActive && (WriteReg == rs)) ? WriteData : regFile_q[rs];
   assign DataB = (rt == 5'd0) ? 32'd0 :
                  (writeActive && (WriteReg == rt)) ? WriteData : regFile_q[rt];
   assign DataC = (WriteRegister == 5'd0) ? 32'd0 :
                  (writeActive && (WriteReg == WriteRegister)) ? WriteData : regFile_q[WriteRegister];

   always_comb begin
      Link         = 1'b0;
      RegDest      = 1'b0;
      Jump         = 1'b0;
      Branch       = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      ALUSrc       = 1'b0;
      RegWrite     = 1'b0;
      JumpRegister = 1'b0;
      SignOrZero   = 1'b0;
      Syscall      = 1'b0;
      ALUControl   = 6'b000000;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
               FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA: begin
                  RegDest    = 1'b1;
                  RegWrite   = 1'b1;
                  ALUControl = funct;
               end
               FN_JR: begin
                  Jump         = 1'b1;
                  JumpRegister = 1'b1;
                  ALUControl   = FN_JR;
               end
               FN_JALR: begin
                  Jump         = 1'b1;
                  JumpRegister = 1'b1;
                  Link         = 1'b1;
                  RegDest      = 1'b1;
                  RegWrite     = 1'b1;
                  ALUControl   = FN_ADDU;
               end
               FN_SYSCALL: begin
                  Syscall    = 1'b1;
                  ALUControl = FN_SYSCALL;
               end
               default: ;
            endcase
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            ALUSrc     = 1'b1;
            RegWrite   = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = (opcode == OP_ADDIU) ? FN_ADDU :
                         (opcode == OP_SLTI)  ? FN_SLT  : FN_SLTU;
         end
         // Logical immediates zero-extend; LUI keeps its own opcode as the ALU code.
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ALUSrc     = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = (opcode == OP_ANDI) ? FN_AND :
                         (opcode == OP_ORI)  ? FN_OR  :
                         (opcode == OP_XORI) ? FN_XOR : OP_LUI;
         end
         OP_LW, OP_LL: begin
            MemRead    = 1'b1;
            RegWrite   = 1'b1;
            ALUSrc     = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = (opcode == OP_LW) ? FN_ADDU : ALU_LL;
         end
         OP_SW: begin
            MemWrite   = 1'b1;
            ALUSrc     = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = FN_ADDU;
         end
         OP_SC: begin
            MemWrite   = 1'b1;
            RegWrite   = 1'b1;
            ALUSrc     = 1'b1;
            SignOrZero = 1'b1;
            ALUControl = ALU_SC;
         end
         OP_BEQ, OP_BNE: begin
            Branch     = 1'b1;
            ALUControl = opcode;
         end
         OP_J: begin
            Jump = 1'b1;
         end
         OP_JAL: begin
            Jump       = 1'b1;
            Link       = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = FN_ADDU;
         end
         default: ;
      endcase
   end

   assign WriteRegister = RegDest ? rd : (Link ? 5'd31 : rt);

   assign branchTarget = PC_Plus4 + {{14{imm[15]}}, imm, 2'b00};
   assign jumpTarget   = {PC_Plus4[31:28], Instr[25:0], 2'b00};
   assign AltPC        = JumpRegister ? JrValue : (Jump ? jumpTarget : branchTarget);

endmodule

// File: tb/tb_decode_core.sv
// Self-checking bench for decode_core: directed vector table, hand-written register
// file sequences, and randomized instructions checked against a reference model.
module tb_decode_core;

   logic        CLK;
   logic        RESET;
   logic [31:0] Instr;
   logic [31:0] PC_Plus4;
   logic [31:0] JrValue;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        Write;
   logic [31:0] DataA;
   logic [31:0] DataB;
   logic [31:0] DataC;
   logic [4:0]  WriteRegister;
   logic [31:0] AltPC;
   logic        Link, RegDest, Jump, Branch, MemRead, MemWrite;
   logic        ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
   logic [5:0]  ALUControl;
   logic [10:0] flagsAct;

   int checks = 0;
   int errors = 0;

   logic [31:0] refRegs [32];

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] jr;
      logic [10:0] flags;
      logic [5:0]  alu;
      logic [4:0]  wreg;
      logic [31:0] altPc;
      bit          chkAlt;
   } vec_t;

   typedef struct packed {
      logic [10:0] flags;
      logic [5:0]  alu;
      logic [4:0]  wreg;
      logic [31:0] altPc;
   } exp_t;

   vec_t vecs [$];

   decode_core dut (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .PC_Plus4(PC_Plus4), .JrValue(JrValue),
      .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write),
      .DataA(DataA), .DataB(DataB), .DataC(DataC), .WriteRegister(WriteRegister),
      .AltPC(AltPC), .Link(Link), .RegDest(RegDest), .Jump(Jump), .Branch(Branch),
      .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .JumpRegister(JumpRegister), .SignOrZero(SignOrZero), .Syscall(Syscall),
      .ALUControl(ALUControl)
   );

   assign flagsAct = {Link, RegDest, Jump, Branch, MemRead, MemWrite,
                      ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   function automatic void addVec(input string name, input logic [31:0] instr,
                                  input logic [31:0] pc4, input logic [10:0] flags,
                                  input logic [5:0] alu, input logic [4:0] wreg,
                                  input logic [31:0] altPc, input bit chkAlt);
      vec_t v;
      v.name = name; v.instr = instr; v.pc4 = pc4; v.jr = 32'h0040_0100;
      v.flags = flags; v.alu = alu; v.wreg = wreg; v.altPc = altPc; v.chkAlt = chkAlt;
      vecs.push_back(v);
   endfunction

   // Reference decoder built from mnemonic tables rather than a bit-level decode.
   function automatic exp_t refDecode(input logic [31:0] ins, input logic [31:0] pc4,
                                      input logic [31:0] jr);
      logic [5:0] rAlu [11];
      logic [5:0] iOp [11];
      logic [5:0] iAlu [11];
      bit         iSext [11];
      bit         iLoad [11];
      bit         iStore [11];
      bit         iWrite [11];
      bit link, regDest, jump, branch, memRead, memWrite, aluSrc, regWrite, jumpReg, sext, sys;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] dest;
      longint     tgt;
      exp_t       e;
      rAlu = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
      iOp    = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38};
      iAlu   = '{6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h0F, 6'h21, 6'h21, 6'h28, 6'h36};
      iSext  = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
      iLoad  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
      iStore = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      iWrite = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
      {link, regDest, jump, branch, memRead, memWrite, aluSrc, regWrite, jumpReg, sext, sys} = '0;
      op = ins[31:26];
      fn = ins[5:0];
      e.alu = 6'd0;
      if (op == 6'd0) begin
         foreach (rAlu[k]) begin
            if (rAlu[k] == fn) begin
               regDest = 1; regWrite = 1; e.alu = fn;
            end
         end
         if (fn == 6'h08) begin jump = 1; jumpReg = 1; e.alu = 6'h08; end
         if (fn == 6'h09) begin jump = 1; jumpReg = 1; link = 1; regDest = 1; regWrite = 1; e.alu = 6'h21; end
         if (fn == 6'h0C) begin sys = 1; e.alu = 6'h0C; end
      end else if (op == 6'h04 || op == 6'h05) begin
         branch = 1; e.alu = op;
      end else if (op == 6'h02) begin
         jump = 1;
      end else if (op == 6'h03) begin
         jump = 1; link = 1; regWrite = 1; e.alu = 6'h21;
      end else begin
         foreach (iOp[k]) begin
            if (iOp[k] == op) begin
               aluSrc = 1; sext = iSext[k]; memRead = iLoad[k]; memWrite = iStore[k];
               regWrite = iWrite[k]; e.alu = iAlu[k];
            end
         end
      end
      e.flags = {link, regDest, jump, branch, memRead, memWrite, aluSrc, regWrite, jumpReg, sext, sys};
      dest = regDest ? ins[15:11] : (link ? 5'd31 : ins[20:16]);
      e.wreg = dest;
      if (jumpReg) begin
         e.altPc = jr;
      end else if (jump) begin
         tgt = longint'(pc4 / 32'h1000_0000) * 64'h1000_0000 + longint'(ins[25:0]) * 4;
         e.altPc = tgt[31:0];
      end else begin
         tgt = longint'(pc4) + longint'($signed(ins[15:0])) * 4;
         e.altPc = tgt[31:0];
      end
      return e;
   endfunction

   function automatic logic [31:0] refRead(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
      if (RESET && Write && WriteReg == addr) return WriteData;
      return refRegs[addr];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc4,
                                input logic [31:0] jr);
      Instr = ins;
      PC_Plus4 = pc4;
      JrValue = jr;
   endtask

   task automatic writeRegister(input logic [4:0] addr, input logic [31:0] data);
      @(negedge CLK);
      Write = 1'b1;
      WriteReg = addr;
      WriteData = data;
      @(posedge CLK);
      #1;
      Write = 1'b0;
      if (addr != 5'd0) refRegs[addr] = data;
   endtask

   task automatic clearModel();
      for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
   endtask

   initial begin
      exp_t        e;
      logic [31:0] ins;
      logic [5:0]  opList [17];
      logic [5:0]  fnList [15];

      addVec("addu",   rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h21),     32'h0040_0010, 11'b01000001000, 6'h21, 5'd3,  32'h0, 0);
      addVec("subu",   rType(5'd1, 5'd2, 5'd4, 5'd0, 6'h23),     32'h0040_0010, 11'b01000001000, 6'h23, 5'd4,  32'h0, 0);
      addVec("sra",    rType(5'd0, 5'd2, 5'd6, 5'd3, 6'h03),     32'h0040_0010, 11'b01000001000, 6'h03, 5'd6,  32'h0, 0);
      addVec("jr",     rType(5'd9, 5'd0, 5'd0, 5'd0, 6'h08),     32'h0040_0010, 11'b00100000100, 6'h08, 5'd0,  32'h0040_0100, 1);
      addVec("jalr",   rType(5'd9, 5'd0, 5'd17, 5'd0, 6'h09),    32'h0040_0010, 11'b11100001100, 6'h21, 5'd17, 32'h0040_0100, 1);
      addVec("syscall", 32'h0000_000C,                           32'h0040_0010, 11'b00000000001, 6'h0C, 5'd0,  32'h0, 0);
      addVec("badfn",  rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),     32'h0040_0010, 11'b00000000000, 6'h00, 5'd2,  32'h0, 0);
      addVec("addiu",  iType(6'h09, 5'd1, 5'd8, 16'hFFFF),       32'h0040_0010, 11'b00000011010, 6'h21, 5'd8,  32'h0, 0);
      addVec("andi",   iType(6'h0C, 5'd1, 5'd9, 16'h00FF),       32'h0040_0010, 11'b00000011000, 6'h24, 5'd9,  32'h0, 0);
      addVec("lui",    iType(6'h0F, 5'd0, 5'd10, 16'h1234),      32'h0040_0010, 11'b00000011000, 6'h0F, 5'd10, 32'h0, 0);
      addVec("sltiu",  iType(6'h0B, 5'd1, 5'd11, 16'h8000),      32'h0040_0010, 11'b00000011010, 6'h2B, 5'd11, 32'h0, 0);
      addVec("lw",     iType(6'h23, 5'd29, 5'd12, 16'h0010),     32'h0040_0010, 11'b00001011010, 6'h21, 5'd12, 32'h0, 0);
      addVec("sw",     iType(6'h2B, 5'd29, 5'd13, 16'h0004),     32'h0040_0010, 11'b00000110010, 6'h21, 5'd13, 32'h0, 0);
      addVec("ll",     iType(6'h30, 5'd4, 5'd14, 16'h0000),      32'h0040_0010, 11'b00001011010, 6'h28, 5'd14, 32'h0, 0);
      addVec("sc",     iType(6'h38, 5'd4, 5'd15, 16'h0000),      32'h0040_0010, 11'b00000111010, 6'h36, 5'd15, 32'h0, 0);
      addVec("beq",    iType(6'h04, 5'd1, 5'd2, 16'hFFFF),       32'h0040_0010, 11'b00010000000, 6'h04, 5'd2,  32'h0040_000C, 1);
      addVec("bne",    iType(6'h05, 5'd1, 5'd2, 16'h7FFF),       32'h0040_0010, 11'b00010000000, 6'h05, 5'd2,  32'h0042_000C, 1);
      addVec("beqneg", iType(6'h04, 5'd0, 5'd0, 16'h8000),       32'h0001_0000, 11'b00010000000, 6'h04, 5'd0,  32'hFFFF_0000, 1);
      addVec("bnewrap", iType(6'h05, 5'd0, 5'd0, 16'h0008),      32'hFFFF_FFF0, 11'b00010000000, 6'h05, 5'd0,  32'h0000_0010, 1);
      addVec("j",      jType(6'h02, 26'h0100000),                32'hA000_0004, 11'b00100000000, 6'h00, 5'd16, 32'hA040_0000, 1);
      addVec("jal",    jType(6'h03, 26'h0100000),                32'h0040_0004, 11'b10100001000, 6'h21, 5'd31, 32'h0040_0000, 1);
      addVec("badop",  iType(6'h3F, 5'd1, 5'd2, 16'h0000),       32'h0040_0010, 11'b00000000000, 6'h00, 5'd2,  32'h0, 0);

      clearModel();
      RESET = 1'b0;
      Write = 1'b1;
      WriteReg = 5'd5;
      WriteData = 32'hFFFF_0000;
      applyStimulus(rType(5'd5, 5'd0, 5'd5, 5'd0, 6'h21), 32'h0040_0004, 32'h0);

      // Writes and write-through are blocked while reset is held.
      #2;
      checkOutput("reset_bypass_blocked", DataA, 32'd0);
      checkOutput("reset_dataC", DataC, 32'd0);
      @(posedge CLK);
      #1;
      checkOutput("reset_write_blocked", DataA, 32'd0);
      @(negedge CLK);
      Write = 1'b0;
      RESET = 1'b1;

      writeRegister(5'd5, 32'hDEAD_BEEF);
      applyStimulus(rType(5'd5, 5'd0, 5'd3, 5'd0, 6'h21), 32'h0040_0004, 32'h0);
      #1;
      checkOutput("addu_dataA", DataA, 32'hDEAD_BEEF);
      checkOutput("addu_dataB", DataB, 32'd0);
      checkOutput("addu_wreg", {27'd0, WriteRegister}, 32'd3);
      checkOutput("addu_regdest", {31'd0, RegDest}, 32'd1);
      checkOutput("addu_alu", {26'd0, ALUControl}, 32'h21);

      @(negedge CLK);
      Write = 1'b1;
      WriteReg = 5'd0;
      WriteData = 32'h0000_1234;
      applyStimulus(rType(5'd0, 5'd0, 5'd0, 5'd0, 6'h21), 32'h0040_0004, 32'h0);
      #2;
      checkOutput("r0_bypass", DataA, 32'd0);
      @(posedge CLK);
      #1;
      checkOutput("r0_after_write", DataA, 32'd0);
      @(negedge CLK);
      WriteReg = 5'd7;
      WriteData = 32'hCAFE_F00D;
      applyStimulus(rType(5'd1, 5'd7, 5'd7, 5'd0, 6'h21), 32'h0040_0004, 32'h0);
      #2;
      checkOutput("r7_bypass_B", DataB, 32'hCAFE_F00D);
      checkOutput("r7_bypass_C", DataC, 32'hCAFE_F00D);
      @(posedge CLK);
      #1;
      Write = 1'b0;
      refRegs[7] = 32'hCAFE_F00D;
      #1;
      checkOutput("r7_stored", DataB, 32'hCAFE_F00D);

      foreach (vecs[i]) begin
         @(negedge CLK);
         applyStimulus(vecs[i].instr, vecs[i].pc4, vecs[i].jr);
         #2;
         checkOutput({vecs[i].name, "_flags"}, {21'd0, flagsAct}, {21'd0, vecs[i].flags});
         checkOutput({vecs[i].name, "_alu"}, {26'd0, ALUControl}, {26'd0, vecs[i].alu});
         checkOutput({vecs[i].name, "_wreg"}, {27'd0, WriteRegister}, {27'd0, vecs[i].wreg});
         if (vecs[i].chkAlt) checkOutput({vecs[i].name, "_altpc"}, AltPC, vecs[i].altPc);
      end

      opList = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B,
                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h30, 6'h38};
      fnList = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                 6'h03, 6'h08, 6'h09, 6'h0C, 6'h20};
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) ins[31:26] = opList[$urandom_range(0, 16)];
         if ($urandom_range(0, 9) == 0) ins[31:26] = 6'h2B;
         if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = fnList[$urandom_range(0, 14)];
         applyStimulus(ins, $urandom, $urandom);
         Write = 1'($urandom_range(0, 1));
         WriteReg = 5'($urandom);
         WriteData = $urandom;
         #2;
         e = refDecode(Instr, PC_Plus4, JrValue);
         checkOutput("rnd_flags", {21'd0, flagsAct}, {21'd0, e.flags});
         checkOutput("rnd_alu", {26'd0, ALUControl}, {26'd0, e.alu});
         checkOutput("rnd_wreg", {27'd0, WriteRegister}, {27'd0, e.wreg});
         checkOutput("rnd_altpc", AltPC, e.altPc);
         checkOutput("rnd_dataA", DataA, refRead(Instr[25:21]));
         checkOutput("rnd_dataB", DataB, refRead(Instr[20:16]));
         checkOutput("rnd_dataC", DataC, refRead(e.wreg));
         if (Write && WriteReg != 5'd0) refRegs[WriteReg] = WriteData;
      end

      writeRegister(5'd9, 32'h1357_9BDF);
      writeRegister(5'd31, 32'h8000_0001);

      // Reset asserted between clock edges must clear every register at once.
      @(negedge CLK);
      Write = 1'b0;
      #1;
      RESET = 1'b0;
      clearModel();
      #1;
      for (int r = 0; r < 32; r++) begin
         applyStimulus(rType(5'(r), 5'd0, 5'd0, 5'd0, 6'h21), 32'h0, 32'h0);
         #0.1;
         checkOutput($sformatf("midreset_r%0d", r), DataA, 32'd0);
      end
      Write = 1'b1;
      WriteReg = 5'd9;
      WriteData = 32'h0000_0055;
      applyStimulus(rType(5'd9, 5'd0, 5'd0, 5'd0, 6'h21), 32'h0, 32'h0);
      @(posedge CLK);
      #1;
      checkOutput("midreset_write_blocked", DataA, 32'd0);
      @(negedge CLK);
      Write = 1'b0;
      RESET = 1'b1;
      #2;
      checkOutput("post_reset_r9", DataA, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
